// File: rtl/ad9228_fifo_drain.sv
// ad9228_fifo_drain
// Round-robin drain of the AD9228 reader's per-channel sample FIFOs.
// Lives in the FIFO read-clock domain. It drives the reader's channel
// address mux and a one-hot read strobe. Each sample leaves as one 32-bit
// word on a valid/ready stream, tagged with the following fields:
//   [31:28] per-channel sequence count
//   [27:24] channel index
//   [23]    full flag
//   [11:0]  sample (zero-padded up to bit 15)
// Optional feature macro: AD9228_DRAIN_FULL_FLAG_EN.
//   Defined:   the selected FIFO's full flag is captured with each sample,
//              and overflow_seen becomes a sticky report of it.
//   Undefined: the full bit is always 0 and overflow_seen is tied low.
module ad9228_fifo_drain #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int RD_LATENCY   = 1,
    parameter int BURST        = 4,
    localparam int AW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drain_en,
    output logic [AW-1:0]           fifo_addr,
    output logic [NUM_CHANNELS-1:0] fifo_rd_en,
    input  logic                    fifo_not_empty,
    input  logic                    fifo_full,
    input  logic [DATA_WIDTH-1:0]   fifo_dout,
    output logic [31:0]             m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    busy,
    output logic                    overflow_seen
);

    // Last WAIT count before the read data is valid (unused when RD_LATENCY=1).
    localparam int WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           addr_q;
    logic [NUM_CHANNELS-1:0] rd_en_q;
    logic [31:0]             tdata_q;
    logic                    tvalid_q;
    logic                    busy_q;
    logic [7:0]              burst_q;
    logic [1:0]              wait_q;
    logic [3:0]              seq_q [NUM_CHANNELS];
    logic                    out_entry;
    logic                    cap_full;

    // Strictly ascending channel order with wrap; a single channel never moves.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (NUM_CHANNELS == 1) return '0;
        if (a == AW'(NUM_CHANNELS - 1)) return '0;
        return a + 1'b1;
    endfunction

    function automatic logic [NUM_CHANNELS-1:0] onehot(input logic [AW-1:0] a);
        logic [NUM_CHANNELS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (a == AW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [31:0] pack_word(input logic [3:0]            seq,
                                              input logic [AW-1:0]         ch,
                                              input logic                  full,
                                              input logic [DATA_WIDTH-1:0] s);
        logic [15:0] samp;
        samp = '0;
        samp[DATA_WIDTH-1:0] = s;
        return {seq, 4'(ch), full, 7'b0, samp};
    endfunction

    // The read data becomes valid on this edge, so the word is captured here.
    assign out_entry = ((state_q == S_READ) && (RD_LATENCY == 1)) ||
                       ((state_q == S_WAIT) && (wait_q == 2'(WAIT_LAST)));

`ifdef AD9228_DRAIN_FULL_FLAG_EN
    logic ovf_q;

    assign cap_full = fifo_full;

    // Sticky record of any sample that was read out of a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (out_entry && fifo_full) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_seen = ovf_q;
`else
    logic unused_full;

    assign unused_full   = fifo_full;
    assign cap_full      = 1'b0;
    assign overflow_seen = 1'b0;
`endif

    // Drain FSM. The address only moves on transitions, so the reader's
    // combinational mux stays stable from CHECK through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rd_en_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            burst_q  <= '0;
            wait_q   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (drain_en) begin
                        state_q <= S_CHECK;
                        busy_q  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!drain_en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fifo_not_empty) begin
                        state_q <= S_READ;
                        rd_en_q <= onehot(addr_q);
                    end else begin
                        addr_q  <= next_addr(addr_q);
                        burst_q <= '0;
                    end
                end
                S_READ: begin
                    rd_en_q <= '0;
                    wait_q  <= '0;
                    if (out_entry) begin
                        state_q  <= S_OUT;
                        tvalid_q <= 1'b1;
                        tdata_q  <= pack_word(seq_q[addr_q], addr_q, cap_full, fifo_dout);
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (out_entry) begin
                        state_q  <= S_OUT;
                        tvalid_q <= 1'b1;
                        tdata_q  <= pack_word(seq_q[addr_q], addr_q, cap_full, fifo_dout);
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_OUT: begin
                    if (m_tready) begin
                        tvalid_q       <= 1'b0;
                        seq_q[addr_q]  <= seq_q[addr_q] + 4'd1;
                        if ((burst_q + 8'd1) == 8'(BURST)) begin
                            addr_q  <= next_addr(addr_q);
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_q + 8'd1;
                        end
                        if (drain_en) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_addr  = addr_q;
    assign fifo_rd_en = rd_en_q;
    assign m_tdata    = tdata_q;
    assign m_tvalid   = tvalid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ad9228_fifo_drain.sv
// Bench for ad9228_fifo_drain at default parameters. It models four
// first-word-fall-through FIFOs behind the reader mux and a scoreboard of
// tagged words that is filled when a sample is popped.
module tb_ad9228_fifo_drain;
    localparam int NCH = 4;
    localparam int DW  = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           drain_en = 1'b0;
    logic [1:0]     fifo_addr;
    logic [NCH-1:0] fifo_rd_en;
    logic           fifo_not_empty = 1'b0;
    logic           fifo_full = 1'b0;
    logic [DW-1:0]  fifo_dout = '0;
    logic [31:0]    m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic           busy;
    logic           overflow_seen;

    always #5 clk = ~clk;

    ad9228_fifo_drain dut (
        .clk           (clk),
        .rst           (rst),
        .drain_en      (drain_en),
        .fifo_addr     (fifo_addr),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_not_empty(fifo_not_empty),
        .fifo_full     (fifo_full),
        .fifo_dout     (fifo_dout),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .busy          (busy),
        .overflow_seen (overflow_seen)
    );

    logic [DW-1:0] fq [NCH][$];
    logic          full_cfg [NCH];
    logic [31:0]   exp_q [$];
    logic [31:0]   got_q [$];
    int            pop_cnt [NCH];
    int            rd_pulses = 0;
    bit            pend = 1'b0;
    int            pend_ch = 0;
    logic          pend_full = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input int seq, input int ch, input logic full,
                                            input logic [11:0] s);
        logic [3:0] sq;
        logic [3:0] c;
        logic       fb;
        sq = 4'(seq);
        c  = 4'(ch);
`ifdef AD9228_DRAIN_FULL_FLAG_EN
        fb = full;
`else
        fb = 1'b0;
`endif
        return {sq, c, fb, 7'b0, 4'b0, s};
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NCH; i++) begin
            if (fq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // FIFO model, scoreboard and mux drive, all evaluated on the falling edge.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            exp_q.push_back(mk_word(pop_cnt[pend_ch], pend_ch, pend_full, fq[pend_ch][0]));
            void'(fq[pend_ch].pop_front());
            pop_cnt[pend_ch]++;
        end
        if (fifo_rd_en != '0) begin
            rd_pulses++;
            check_eq("rd_en_onehot", 32'($countones(fifo_rd_en)), 32'd1);
            for (int i = 0; i < NCH; i++) begin
                if (fifo_rd_en[i]) pend_ch = i;
            end
            check_eq("rd_nonempty", 32'(fq[pend_ch].size() != 0), 32'd1);
            pend_full = fifo_full;
            if (fq[pend_ch].size() != 0) begin
                if (rst) void'(fq[pend_ch].pop_front());
                else pend = 1'b1;
            end
        end
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < NCH; i++) pop_cnt[i] = 0;
        end
        if (m_tvalid && m_tready && !rst) begin
            if (exp_q.size() == 0) check_eq("sb_extra_word", 32'(exp_q.size()), 32'd1);
            else check_eq("sb_word", m_tdata, exp_q.pop_front());
            got_q.push_back(m_tdata);
        end
        fifo_not_empty = (fq[fifo_addr].size() != 0);
        fifo_dout      = fifo_not_empty ? fq[fifo_addr][0] : '0;
        fifo_full      = full_cfg[fifo_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NCH; i++) begin
            fq[i].delete();
            full_cfg[i] = 1'b0;
        end
        got_q.delete();
        drain_en = 1'b0;
        m_tready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd_pulses = 0;
    endtask

    task automatic drain_all(input string tag, input int budget);
        int n;
        n = 0;
        drain_en = 1'b1;
        m_tready = 1'b1;
        while (!(all_empty() && exp_q.size() == 0 && !m_tvalid && !pend) && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(n < budget), 32'd1);
        drain_en = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_rd(input string tag);
        int n;
        n = 0;
        while (fifo_rd_en == '0 && n < 100) begin
            tick();
            n++;
        end
        check_eq({tag, "_rd_seen"}, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] hold;
        logic [7:0]  top;
        bit          stable;
        bit          vld_hi;
        int          n;
        int          idx;

        for (int i = 0; i < NCH; i++) begin
            full_cfg[i] = 1'b0;
            pop_cnt[i]  = 0;
        end
        do_reset();

        // Reset state
        check_eq("rst_addr", 32'(fifo_addr), 32'd0);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("rst_tdata", m_tdata, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(overflow_seen), 32'd0);

        // Only channel 2 holds a sample
        fq[2].push_back(12'hABC);
        drain_en = 1'b1;
        m_tready = 1'b1;
        wait_rd("a");
        check_eq("a_rd_en", 32'(fifo_rd_en), 32'h4);
        tick();
        check_eq("a_tvalid", 32'(m_tvalid), 32'd1);
        check_eq("a_tdata", m_tdata, 32'h02000ABC);
        tick();
        check_eq("a_addr_hold", 32'(fifo_addr), 32'd2);
        tick();
        check_eq("a_addr_3", 32'(fifo_addr), 32'd3);
        tick();
        check_eq("a_addr_0", 32'(fifo_addr), 32'd0);
        tick();
        check_eq("a_addr_1", 32'(fifo_addr), 32'd1);
        tick();
        check_eq("a_addr_2", 32'(fifo_addr), 32'd2);
        for (int i = 0; i < 8; i++) tick();
        check_eq("a_rd_pulses", 32'(rd_pulses), 32'd1);
        drain_all("a", 50);

        // Four channels of six samples each with BURST=4
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < 6; i++) fq[c].push_back(12'((c << 8) | (i << 4) | 5));
        end
        drain_all("b", 600);
        check_eq("b_count", 32'(got_q.size()), 32'd24);
        idx = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < ((r == 0) ? 4 : 2); k++) begin
                    n = r * 4 + k;
                    w = (idx < got_q.size()) ? got_q[idx] : 32'hDEADBEEF;
                    check_eq("b_order", w, mk_word(n, c, 1'b0, 12'((c << 8) | (n << 4) | 5)));
                    idx++;
                end
            end
        end

        // Downstream stall held for 20 cycles in OUT
        do_reset();
        fq[1].push_back(12'h5A1);
        fq[1].push_back(12'h5A2);
        drain_en = 1'b1;
        n = 0;
        while (!m_tvalid && n < 50) begin
            tick();
            n++;
        end
        check_eq("c_tvalid_seen", 32'(m_tvalid), 32'd1);
        check_eq("c_first_word", m_tdata, 32'h010005A1);
        hold = m_tdata;
        rd_pulses = 0;
        stable = 1'b1;
        vld_hi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_tdata !== hold) stable = 1'b0;
            if (m_tvalid !== 1'b1) vld_hi = 1'b0;
        end
        check_eq("c_tdata_stable", 32'(stable), 32'd1);
        check_eq("c_tvalid_held", 32'(vld_hi), 32'd1);
        check_eq("c_no_reads", 32'(rd_pulses), 32'd0);
        drain_all("c", 100);
        check_eq("c_count", 32'(got_q.size()), 32'd2);

        // Seventeen words from channel 1: the sequence count wraps
        do_reset();
        for (int i = 0; i < 17; i++) fq[1].push_back(12'(i + 1));
        drain_all("d", 1000);
        check_eq("d_count", 32'(got_q.size()), 32'd17);
        w = (got_q.size() > 16) ? got_q[16] : 32'hFFFFFFFF;
        top = w[31:24];
        check_eq("d_wrap_17th", 32'(top), 32'h01);
        w = (got_q.size() > 15) ? got_q[15] : 32'hFFFFFFFF;
        top = w[31:24];
        check_eq("d_16th", 32'(top), 32'hF1);

        // Sample read from a full FIFO
        do_reset();
        full_cfg[0] = 1'b1;
        fq[0].push_back(12'h123);
        drain_all("e", 100);
        w = (got_q.size() > 0) ? got_q[0] : 32'hFFFFFFFF;
`ifdef AD9228_DRAIN_FULL_FLAG_EN
        check_eq("e_word_full", w, 32'h00800123);
        check_eq("e_ovf", 32'(overflow_seen), 32'd1);
`else
        check_eq("e_word_full", w, 32'h00000123);
        check_eq("e_ovf", 32'(overflow_seen), 32'd0);
`endif
        full_cfg[0] = 1'b0;
        fq[0].push_back(12'h456);
        drain_all("e2", 100);
        w = (got_q.size() > 1) ? got_q[1] : 32'hFFFFFFFF;
        check_eq("e_word_after", w, 32'h10000456);
`ifdef AD9228_DRAIN_FULL_FLAG_EN
        check_eq("e_ovf_sticky", 32'(overflow_seen), 32'd1);
`else
        check_eq("e_ovf_sticky", 32'(overflow_seen), 32'd0);
`endif

        // drain_en falls while a sample is in flight
        do_reset();
        fq[0].push_back(12'h321);
        drain_en = 1'b1;
        m_tready = 1'b1;
        wait_rd("f");
        drain_en = 1'b0;
        tick();
        tick();
        tick();
        check_eq("f_count", 32'(got_q.size()), 32'd1);
        w = (got_q.size() > 0) ? got_q[0] : 32'hFFFFFFFF;
        check_eq("f_word", w, 32'h00000321);
        check_eq("f_idle", 32'(busy), 32'd0);

        // Reset asserted while the read strobe is high
        do_reset();
        fq[3].push_back(12'h7A0);
        fq[3].push_back(12'h7A1);
        drain_en = 1'b1;
        m_tready = 1'b1;
        wait_rd("g");
        rst = 1'b1;
        tick();
        check_eq("g_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("g_tvalid", 32'(m_tvalid), 32'd0);
        check_eq("g_addr", 32'(fifo_addr), 32'd0);
        check_eq("g_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        drain_en = 1'b0;
        tick();
        drain_all("g", 100);
        w = (got_q.size() > 0) ? got_q[0] : 32'hFFFFFFFF;
        check_eq("g_after_rst", w, 32'h030007A1);

        check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
